load_store_unit: RTL and testbench

// - Memory-access stage between execute and the word-wide data memory (1024 x 32, word-indexed,

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, request record.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Request fields held for the lifetime of one access (address kept separately, it is parameterised).
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  // Encoding/alignment legality of an access; range checking needs the depth and lives in the top.
  function automatic logic lsu_bad_access(input logic store, input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = store;
      F3_HU:   bad = store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering: extracts/extends load data from a memory word and merges store data into it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend loads by size/signedness; merge store lanes into the fetched word.
  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (funct3)
      F3_B:  begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        store_word = word;
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H:  begin
        load_data = {{16{half_sel[15]}}, half_sel};
        store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      F3_BU: load_data = {24'h0, byte_sel};
      F3_HU: load_data = {16'h0, half_sel};
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time, RMW for sub-word stores, sign/zero-extended loads.
// Latency from accept: error 1, load/SW 2, SB/SH 3 cycles to response.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  output logic              mem_we,
  input  logic [31:0]       mem_rd
);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       mem_wd_q, mem_wd_d;

  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] cur_idx;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign req_idx = {2'b00, req_addr[ADDR_W-1:2]};
  assign cur_idx = {2'b00, addr_q[ADDR_W-1:2]};
  assign req_err = lsu_bad_access(req_store, req_funct3, req_addr[1:0])
                 | (req_idx >= ADDR_W'(DEPTH_WORDS));

  // Lane steering always works on the live memory word, which is only meaningful in RD.
  lsu_lane_align u_align (
    .word       (mem_rd),
    .addr_lo    (addr_q[1:0]),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next-state and next-register values; memory address/data are zero unless entering RD or WR.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_a_d  = '0;
    mem_wd_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{store: req_store, funct3: req_funct3, wdata: req_wdata};
          addr_d  = req_addr;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_store && (req_funct3 == F3_W)) begin
            state_d  = WR;
            mem_a_d  = req_idx;
            mem_wd_d = req_wdata;
          end else begin
            state_d = RD;
            mem_a_d = req_idx;
          end
        end
      end
      RD: begin
        if (req_q.store) begin
          state_d  = WR;
          mem_a_d  = cur_idx;
          mem_wd_d = store_word;
        end else begin
          state_d = RESP;
          rdata_d = load_data;
        end
      end
      WR: begin
        state_d = RESP;
      end
      default: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;
  // Reset in the WR cycle must suppress the write that edge would otherwise commit.
  assign mem_we    = (state_q == WR) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: random and directed accesses against a word-array reference model.
// Latency: checks response timing relative to the accept cycle.
// Backpressure: randomly throttles rsp_ready, with a forced multi-cycle stall.
module tb_load_store_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read returning 0 while writing, write on posedge.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  assign mem_rd = mem_we ? 32'h0 : ((mem_a < 32'(DEPTH)) ? mem[mem_a[9:0]] : 32'h0);
  always @(posedge clk) if (mem_we && (mem_a < 32'(DEPTH))) mem[mem_a[9:0]] <= mem_wd;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    logic        wr;
    logic [31:0] idx;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  bit   skip_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte-addressed semantics computed with shifts and masks over the word array.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int unsigned idx, off, sz;
    logic [31:0] mask, w, v;
    bit          bad;
    idx = a >> 2;
    off = a % 4;
    sz  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    bad = (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3 >= 3'd4) || ((off % sz) != 0) || (idx >= DEPTH);
    e.rdata = 32'h0; e.err = bad; e.wr = 1'b0; e.idx = idx; e.wd = 32'h0; e.acc = 0; e.lat = 1;
    if (!bad) begin
      w    = ref_mem[idx];
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      if (!st) begin
        v = (w >> (8 * off)) & mask;
        if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        e.rdata = v;
        e.lat   = 2;
      end else begin
        e.wd = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        ref_mem[idx] = e.wd;
        e.wr  = 1'b1;
        e.lat = (sz == 4) ? 2 : 3;
      end
    end
    return e;
  endfunction

  // Response throttling: forced stall cycles while valid, otherwise random readiness.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) hold_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: write-port, latency, stability and response checks against the scoreboard.
  logic [31:0] hold_rdata;
  logic        hold_err;
  bit          in_rsp = 1'b0;
  bit          after_hs = 1'b0;
  int          we_cnt = 0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0; after_hs = 1'b0; we_cnt = 0;
    end else begin
      if (after_hs) begin
        after_hs = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_handshake_idle: req_ready %b rsp_valid %b, want 1 0", req_ready, rsp_valid);
        end
      end
      if (mem_we && !skip_we) begin
        we_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: mem_a %h mem_wd %h with nothing outstanding", mem_a, mem_wd);
        end else if (mem_a !== exp_q[0].idx || mem_wd !== exp_q[0].wd) begin
          errors++;
          $display("FAIL write_port: a %h wd %h, want a %h wd %h", mem_a, mem_wd, exp_q[0].idx, exp_q[0].wd);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_resp: req_ready %b, want 0", req_ready);
        end
        if (!in_rsp) begin
          in_rsp = 1'b1; hold_rdata = rsp_rdata; hold_err = rsp_err;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rdata %h err %b with nothing outstanding", rsp_rdata, rsp_err);
          end else if (cyc - exp_q[0].acc != exp_q[0].lat) begin
            errors++;
            $display("FAIL latency: %0d cycles, want %0d", cyc - exp_q[0].acc, exp_q[0].lat);
          end
        end else begin
          checks++;
          if (rsp_rdata !== hold_rdata || rsp_err !== hold_err) begin
            errors++;
            $display("FAIL rsp_stable: rdata %h err %b, want %h %b", rsp_rdata, rsp_err, hold_rdata, hold_err);
          end
        end
        if (rsp_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
            errors++;
            $display("FAIL rsp_data: rdata %h err %b, want %h %b", rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
          end
          checks++;
          if (we_cnt != int'(mon_e.wr)) begin
            errors++;
            $display("FAIL write_count: %0d writes, want %0d", we_cnt, mon_e.wr);
          end
          we_cnt = 0; in_rsp = 1'b0; after_hs = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: req_ready %b after %0d cycles, want 1", req_ready, n);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   ok;
    wait_ready(ok);
    if (ok) begin
      e = model(st, f3, a, wd);
      e.acc = cyc;
      exp_q.push_back(e);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_mem(input string name, input int idx, input logic [31:0] want);
    checks++;
    if (mem[idx] !== want) begin
      errors++;
      $display("FAIL %s: mem[%0d] %h, want %h", name, idx, mem[idx], want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          nbad;
    logic [2:0]  f3_tab [8];
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[10] = 32'hDEADBEEF; ref_mem[10] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: req_ready %b rsp_valid %b, want 1 0", req_ready, rsp_valid);
    end
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: rdata %h err %b, want 0 0", rsp_rdata, rsp_err);
    end
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_we: mem_we %b, want 0", mem_we);
    end
    if (mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      errors++; $display("FAIL reset_mem_port: a %h wd %h, want 0 0", mem_a, mem_wd);
    end
    rst = 1'b0;

    // Directed loads on the DEADBEEF word.
    issue(1'b0, 3'b010, 32'h28, 32'h0);
    issue(1'b0, 3'b000, 32'h29, 32'h0);
    issue(1'b0, 3'b100, 32'h29, 32'h0);
    issue(1'b0, 3'b001, 32'h2A, 32'h0);
    // Sub-word stores via read-modify-write.
    issue(1'b1, 3'b000, 32'h2B, 32'h11);
    drain();
    check_mem("sb_merge", 10, 32'h11ADBEEF);
    issue(1'b1, 3'b001, 32'h28, 32'hCAFE);
    drain();
    check_mem("sh_merge", 10, 32'h11ADCAFE);
    // Error cases: misaligned word, misaligned half, out of range, illegal funct3.
    issue(1'b0, 3'b010, 32'h2A, 32'h0);
    issue(1'b1, 3'b001, 32'h29, 32'h5555);
    issue(1'b0, 3'b010, 32'h1000, 32'h0);
    issue(1'b0, 3'b011, 32'h28, 32'h0);
    issue(1'b0, 3'b010, 32'hFFC, 32'h0);
    drain();
    check_mem("errors_no_write", 10, 32'h11ADCAFE);

    // Stalled response followed immediately by another request.
    hold_cnt = 5;
    issue(1'b0, 3'b000, 32'h2B, 32'h0);
    issue(1'b0, 3'b010, 32'h28, 32'h0);
    drain();

    // Reset during the WR cycle of SW 0x28: write blocked, no response.
    skip_we = 1'b1;
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      r = 0;
      @(negedge clk);
      while (!mem_we && r < 10) begin
        @(negedge clk);
        r++;
      end
      checks++;
      if (mem_we !== 1'b1) begin
        errors++; $display("FAIL sw_wr_cycle: mem_we %b, want 1", mem_we);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
        errors++; $display("FAIL we_gated_by_rst: mem_we %b, want 0", mem_we);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++; $display("FAIL post_reset_idle: rsp_valid %b req_ready %b, want 0 1", rsp_valid, req_ready);
        end
      end
      check_mem("rst_blocks_write", 10, 32'h11ADCAFE);
    end
    skip_we = 1'b0;

    // Randomised mix, concentrated on a few words so loads observe earlier stores.
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      f3 = (r < 8) ? f3_tab[$urandom_range(0, 4)] : f3_tab[$urandom_range(5, 7)];
      r  = $urandom_range(0, 19);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else if (r == 2) a = 32'hFFC + $urandom_range(0, 3);
      else             a = $urandom_range(0, 63);
      issue(1'($urandom_range(0, 1)), f3, a, $urandom);
    end
    drain();

    nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
    checks++;
    if (nbad != 0) begin
      errors++; $display("FAIL final_memory: %0d words differ, want 0", nbad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
